// File: rtl/sram_port_pkg.sv
// Shared defaults, FSM state encoding and counter helpers for sram_port_master.
// The VERIFY state exists only when SRAM_PORT_MASTER_WVERIFY_EN is defined.
package sram_port_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 7;
  localparam int unsigned CNT_WIDTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
    ST_VERIFY,
`endif
    ST_CAPTURE,
    ST_RESP
  } state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_port_master.sv
// sram_port_master: single-outstanding request/response front end for a 1RW SRAM macro.
// Define SRAM_PORT_MASTER_WVERIFY_EN to read back and compare every write (rsp_err).
module sram_port_master
  import sram_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  state_e                state_q,     state_d;
  logic                  we_q,        we_d;
  logic                  csb0_q,      csb0_d;
  logic                  web0_q,      web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q,     addr0_d;
  logic [DATA_WIDTH-1:0] din0_q,      din0_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [CNT_WIDTH-1:0]  rd_count_q,  rd_count_d;
  logic [CNT_WIDTH-1:0]  wr_count_q,  wr_count_d;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
  logic                  rsp_err_q,   rsp_err_d;
`endif

  // addr0_q/din0_q double as the registered request address and write data.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ISSUE;
          we_d    = req_we;
          csb0_d  = 1'b0;
          web0_d  = ~req_we;
          addr0_d = req_addr;
          din0_d  = req_wdata;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
          state_d = ST_VERIFY;
          csb0_d  = 1'b0;
          web0_d  = 1'b1;
`else
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
`endif
        end else begin
          state_d = ST_CAPTURE;
        end
      end
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
      ST_VERIFY: state_d = ST_CAPTURE;
`endif
      ST_CAPTURE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
        if (we_q) begin
          rsp_rdata_d = '0;
          rsp_err_d   = (dout0 != din0_q);
        end else begin
          rsp_rdata_d = dout0;
          rsp_err_d   = 1'b0;
        end
`else
        rsp_rdata_d = dout0;
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          if (we_q) wr_count_d = sat_inc(wr_count_q);
          else      rd_count_d = sat_inc(rd_count_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
`ifdef SRAM_PORT_MASTER_WVERIFY_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: doc/sram_port_master.md
SRAM_PORT_MASTER -- requirements
Module: sram_port_master

Interface
REQ-001 Module SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_WIDTH SHALL default to 32; it is the word width.
REQ-003 Parameter ADDR_WIDTH SHALL default to 7; it is the word address width, depth 2**ADDR_WIDTH.
REQ-004 Port clk0 SHALL be an input, 1 bit: clock, rising-edge active.
REQ-005 Port rst0_n SHALL be an input, 1 bit: asynchronous reset, active low.
REQ-006 Port req_valid SHALL be an input, 1 bit: request present.
REQ-007 Port req_ready SHALL be an output, 1 bit: request accepted when high together with req_valid.
REQ-008 Port req_we SHALL be an input, 1 bit: 1 = write, 0 = read.
REQ-009 Port req_addr SHALL be an input, ADDR_WIDTH bits: word address.
REQ-010 Port req_wdata SHALL be an input, DATA_WIDTH bits: write data.
REQ-011 Port rsp_valid SHALL be an output, 1 bit: response present.
REQ-012 Port rsp_ready SHALL be an input, 1 bit: response consumed when high together with rsp_valid.
REQ-013 Port rsp_rdata SHALL be an output, DATA_WIDTH bits: read data; 0 for writes.
REQ-014 Port rsp_err SHALL be an output, 1 bit: write-verify mismatch.
REQ-015 Ports csb0, web0, addr0 and din0 SHALL be outputs of 1, 1, ADDR_WIDTH and DATA_WIDTH bits: macro chip select (active low), write enable (active low), address and write data.
REQ-016 Port dout0 SHALL be an input, DATA_WIDTH bits: macro read data, valid in the cycle after the read edge.
REQ-017 Ports rd_count and wr_count SHALL be outputs, 16 bits each: saturating counts of completed reads and writes.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, VERIFY, CAPTURE and RESP; all macro-side outputs SHALL be registered.
REQ-019 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0. The design holds one request in flight and does not pipeline.
REQ-020 On acceptance at edge N, the design SHALL register the address, data and we values, then enter ISSUE.
REQ-021 In ISSUE, csb0 SHALL be 0 for exactly one cycle, with web0 = ~we, addr0 = the registered address and din0 = the registered data.
REQ-022 Exit from ISSUE SHALL depend on the request type:
- Read: go to CAPTURE.
- Write: go to RESP, or to VERIFY when write-verify is enabled.
REQ-023 In CAPTURE, csb0 SHALL be 1; at the end of the cycle, dout0 SHALL be latched into rsp_rdata and the state SHALL go to RESP.
REQ-024 Response timing SHALL be:
- Read: rsp_valid high from edge N+2.
- Write: rsp_valid high from edge N+1.
- Verified write: rsp_valid high from edge N+3.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready; on the handshake edge the state SHALL go to IDLE.
REQ-026 A new request SHALL NOT be accepted in the cycle in which the response handshake completes; it is accepted from the next IDLE cycle.
REQ-027 Outside ISSUE and VERIFY, csb0 SHALL be 1 and web0 SHALL be 1; addr0 and din0 SHALL hold their last values.
REQ-028 rd_count and wr_count SHALL increment on the response handshake and saturate at 16'hFFFF, with no wrap.
REQ-029 Address 2**ADDR_WIDTH-1 SHALL be handled identically to any other address.

Reset
REQ-030 On rst0_n low, asynchronously, the design SHALL force:
- state to IDLE;
- csb0 = 1 and web0 = 1;
- addr0, din0, rsp_rdata and rsp_err to 0;
- rsp_valid to 0;
- both counters to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response; a transaction pending in ISSUE SHALL see csb0 = 1 immediately.
REQ-032 req_ready SHALL be 1 at the first edge after rst0_n deasserts.

Configuration
REQ-033 Macro SRAM_PORT_MASTER_WVERIFY_EN defined SHALL enable write-verify behaviour:
- after a write ISSUE, VERIFY drives csb0 = 0 and web0 = 1 to the same address for one cycle;
- CAPTURE compares dout0 with the written data;
- rsp_err is set to 1 on mismatch.
REQ-034 Macro SRAM_PORT_MASTER_WVERIFY_EN undefined SHALL remove the VERIFY state, tie rsp_err to 0 and remove the comparison logic.

Structure
REQ-035 Package sram_port_pkg SHALL hold the DATA_WIDTH and ADDR_WIDTH defaults, the state enum typedef and the counter width constant.
REQ-036 The design SHALL be a single module with no sub-module; the macro model is external.

Verification
REQ-037 The bench SHALL cover write then read: write addr 10 data 32'hFACECAFE, then read addr 10 -> rsp_rdata 32'hFACECAFE, rsp_err 0, wr_count 1, rd_count 1.
REQ-038 The bench SHALL cover the read-timing check: request accepted at edge N -> csb0 low only in cycle N+1, and rsp_valid at N+2.
REQ-039 The bench SHALL cover backpressure: hold rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-040 The bench SHALL cover the verify-mismatch case (macro defined): the memory model corrupts bit 0 at addr 7'h3F, write 32'h0000_0001 -> rsp_err 1, rsp_valid at N+3.
REQ-041 The bench SHALL cover reset in ISSUE: assert rst0_n low -> csb0 1 immediately, no rsp_valid, counters 0, req_ready 1 after release.
REQ-042 The bench SHALL cover counter saturation: force rd_count to 16'hFFFE, then do 2 reads -> rd_count 16'hFFFF.
